// File: rtl/accel_job_launcher_pkg.sv
// accel_job_launcher_pkg: shared state encoding, register map and status constants
package accel_job_launcher_pkg;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_WR_OP = 3'd2, S_WR_GO = 3'd3,
                         S_POLL_GAP = 3'd4, S_POLL_RD = 3'd5, S_DONE = 3'd6;
  localparam logic [31:0] OFF_OP = 32'h0, OFF_STATUS = 32'h4, OFF_DATA = 32'h8;
  localparam logic [31:0] STATUS_GO = 32'hFFFF_FFFF, TIMEOUT_TAG = 32'hDEAD_0000;
  function automatic logic [31:0] data_addr(input logic [31:0] base, input logic [7:0] idx);
    return base + OFF_DATA + {22'd0, idx, 2'b00};
  endfunction
endpackage

// File: rtl/accel_job_launcher_if.sv
// accel_job_launcher_if: Wishbone classic master bus
interface accel_job_launcher_if;
  logic wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0] wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  modport master(output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
                 input wbm_dat_i, wbm_ack_i);
  modport slave(input wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
                output wbm_dat_i, wbm_ack_i);
endinterface

// File: rtl/accel_job_launcher_wb_master_xfer.sv
// wb_master_xfer: single Wishbone transaction with ack timeout
module wb_master_xfer #(
  parameter int TIMEOUT = 1023
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic req,
  input  logic we,
  input  logic [31:0] adr,
  input  logic [31:0] dat,
  output logic ack,
  output logic timeout,
  output logic [31:0] rdata,
  accel_job_launcher_if.master bus
);
  logic [31:0] cnt;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      bus.wbm_cyc_o <= 1'b0;
      bus.wbm_stb_o <= 1'b0;
      bus.wbm_we_o <= 1'b0;
      bus.wbm_sel_o <= 4'h0;
      bus.wbm_adr_o <= 32'h0;
      bus.wbm_dat_o <= 32'h0;
      ack <= 1'b0;
      timeout <= 1'b0;
      rdata <= 32'h0;
      cnt <= 32'h0;
    end else begin
      ack <= 1'b0;
      timeout <= 1'b0;
      if (bus.wbm_cyc_o) begin
        cnt <= cnt + 32'd1;
        if (bus.wbm_ack_i) begin
          bus.wbm_cyc_o <= 1'b0;
          bus.wbm_stb_o <= 1'b0;
          bus.wbm_sel_o <= 4'h0;
          ack <= 1'b1;
          rdata <= bus.wbm_dat_i;
        end else if (cnt == 32'(TIMEOUT - 1)) begin
          bus.wbm_cyc_o <= 1'b0;
          bus.wbm_stb_o <= 1'b0;
          bus.wbm_sel_o <= 4'h0;
          timeout <= 1'b1;
        end
      end else if (req && !ack && !timeout) begin
        bus.wbm_cyc_o <= 1'b1;
        bus.wbm_stb_o <= 1'b1;
        bus.wbm_we_o <= we;
        bus.wbm_sel_o <= 4'hF;
        bus.wbm_adr_o <= adr;
        bus.wbm_dat_o <= we ? dat : 32'h0;
        cnt <= 32'h0;
      end
    end
endmodule

// File: rtl/accel_job_launcher.sv
// accel_job_launcher: loads data words, launches an accelerator job and polls its status
module accel_job_launcher
  import accel_job_launcher_pkg::*;
#(
  parameter logic [31:0] ADDR_OFFSET = 32'h3000_0000,
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic start,
  input  logic [31:0] op,
  input  logic [7:0] n_words,
  input  logic din_valid,
  input  logic [31:0] din,
  output logic din_ready,
  output logic busy,
  output logic done,
  output logic err,
  output logic [31:0] result_status,
  accel_job_launcher_if.master wbm
);
  logic [2:0] state;
  logic [31:0] op_q, gap, xadr, xdat, rdata;
  logic [7:0] n_q, idx;
  logic err_q, req, xwe, xack, xto;
  always_comb begin
    req = state == S_LOAD ? din_valid : (state == S_WR_OP || state == S_WR_GO || state == S_POLL_RD);
    xwe = state != S_POLL_RD;
    xadr = state == S_LOAD ? data_addr(ADDR_OFFSET, idx) : ADDR_OFFSET + (state == S_WR_OP ? OFF_OP : OFF_STATUS);
    xdat = state == S_LOAD ? din : state == S_WR_OP ? op_q : STATUS_GO;
  end
  assign din_ready = state == S_LOAD && wbm.wbm_cyc_o && wbm.wbm_ack_i;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign err = done && err_q;
  wb_master_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .req(req), .we(xwe), .adr(xadr), .dat(xdat),
    .ack(xack), .timeout(xto), .rdata(rdata), .bus(wbm)
  );
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= S_IDLE;
      op_q <= 32'h0;
      n_q <= 8'h0;
      idx <= 8'h0;
      gap <= 32'h0;
      err_q <= 1'b0;
      result_status <= 32'h0;
    end else if (xto) begin
      result_status <= TIMEOUT_TAG | {29'd0, state};
      err_q <= 1'b1;
      state <= S_DONE;
    end else
      case (state)
        S_IDLE: if (start) begin
          op_q <= op;
          n_q <= n_words;
          idx <= 8'h0;
          err_q <= 1'b0;
          state <= n_words == 8'd0 ? S_WR_OP : S_LOAD;
        end
        S_LOAD: if (xack) begin
          idx <= idx + 8'd1;
          if (idx == n_q - 8'd1) state <= S_WR_OP;
        end
        S_WR_OP: if (xack) state <= S_WR_GO;
        S_WR_GO: if (xack) begin
          gap <= 32'h0;
          state <= S_POLL_GAP;
        end
        S_POLL_GAP: if (gap == 32'(POLL_GAP - 1)) state <= S_POLL_RD; else gap <= gap + 32'd1;
        S_POLL_RD: if (xack) begin
          if (rdata == STATUS_GO) begin
            gap <= 32'h0;
            state <= S_POLL_GAP;
          end else begin
            result_status <= rdata;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_accel_job_launcher.sv
// tb_accel_job_launcher: scoreboard bench with a reactive Wishbone slave and data feeder
module tb_accel_job_launcher;
  logic wb_clk_i = 1'b0, wb_rst_i = 1'b1, start = 1'b0, din_valid = 1'b0;
  logic [31:0] op = 32'h0, din = 32'h0, result_status;
  logic [7:0] n_words = 8'h0;
  logic din_ready, busy, done, err;
  accel_job_launcher_if wbm();
  accel_job_launcher dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .op(op), .n_words(n_words),
    .din_valid(din_valid), .din(din), .din_ready(din_ready), .busy(busy), .done(done),
    .err(err), .result_status(result_status), .wbm(wbm)
  );
  always #5 wb_clk_i = ~wb_clk_i;
  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat;} xfer_t;
  typedef struct {logic [31:0] status; logic [31:0] mask; logic err;} job_t;
  xfer_t xq[$];
  job_t jq[$];
  logic [31:0] dq[$];
  xfer_t e;
  job_t j;
  int tests = 0, fails = 0, polls_left = 0, run = 0, last_run = 0;
  logic [31:0] final_status = 32'h0;
  logic nak_go = 1'b0, prev_done = 1'b0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    xq.push_back('{1'b1, a, d});
  endtask
  task automatic exp_rd(input int n);
    repeat (n) xq.push_back('{1'b0, 32'h3000_0004, 32'h0});
  endtask
  task automatic exp_job(input logic [31:0] s, input logic [31:0] m, input logic ef);
    jq.push_back('{s, m, ef});
  endtask
  task automatic launch(input logic [31:0] o, input logic [7:0] n);
    @(negedge wb_clk_i);
    start = 1'b1; op = o; n_words = n;
    @(negedge wb_clk_i);
    start = 1'b0; op = 32'h0; n_words = 8'h0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask
  task automatic wait_done(input int budget);
    int i = 0;
    while (done !== 1'b1 && i < budget) begin
      @(negedge wb_clk_i);
      i++;
    end
    check("done_seen", 32'(done), 32'd1);
    @(negedge wb_clk_i);
  endtask
  initial begin
    wbm.wbm_ack_i = 1'b0;
    wbm.wbm_dat_i = 32'h0;
    forever begin
      @(posedge wb_clk_i);
      #2;
      if (wbm.wbm_cyc_o && wbm.wbm_stb_o && !wbm.wbm_ack_i &&
          !(nak_go && wbm.wbm_we_o && wbm.wbm_adr_o == 32'h3000_0004)) begin
        wbm.wbm_ack_i = 1'b1;
        wbm.wbm_dat_i = 32'h0BAD_F00D;
        if (!wbm.wbm_we_o) begin
          if (polls_left > 0) begin
            polls_left--;
            wbm.wbm_dat_i = 32'hFFFF_FFFF;
          end else wbm.wbm_dat_i = final_status;
        end
      end else wbm.wbm_ack_i = 1'b0;
    end
  end
  initial forever begin
    @(negedge wb_clk_i);
    if (din_ready && dq.size() != 0) void'(dq.pop_front());
    din_valid = dq.size() != 0;
    din = dq.size() != 0 ? dq[0] : 32'h0;
  end
  initial forever begin
    @(negedge wb_clk_i);
    if (wbm.wbm_cyc_o) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (wbm.wbm_cyc_o && wbm.wbm_ack_i) begin
      if (xq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_xfer: got adr %h dat %h, expected no transaction", wbm.wbm_adr_o, wbm.wbm_dat_o);
      end else begin
        e = xq.pop_front();
        check("xfer_we", 32'(wbm.wbm_we_o), 32'(e.we));
        check("xfer_adr", wbm.wbm_adr_o, e.adr);
        check("xfer_dat", wbm.wbm_dat_o, e.dat);
        check("xfer_sel", 32'(wbm.wbm_sel_o), 32'hF);
        check("xfer_stb", 32'(wbm.wbm_stb_o), 32'd1);
        check("din_ready", 32'(din_ready), 32'(e.we && e.adr >= 32'h3000_0008));
      end
    end
    if (done) begin
      if (jq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got status %h, expected no completion", result_status);
      end else begin
        j = jq.pop_front();
        check("done_status", result_status & j.mask, j.status);
        check("done_err", 32'(err), 32'(j.err));
        check("busy_in_done", 32'(busy), 32'd1);
        check("done_one_cycle", 32'(prev_done), 32'd0);
      end
    end else if (err) check("err_only_with_done", 32'(err), 32'd0);
    prev_done = done;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end within 200us");
    $fatal(1, "watchdog");
  end
  initial begin
    int cnt;
    int i;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_cyc", 32'(wbm.wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wbm.wbm_stb_o), 32'd0);
    check("rst_sel", 32'(wbm.wbm_sel_o), 32'd0);
    check("rst_adr", wbm.wbm_adr_o, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_status", result_status, 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    dq.push_back(32'h11); dq.push_back(32'h22); dq.push_back(32'h33);
    exp_wr(32'h3000_0008, 32'h11); exp_wr(32'h3000_000C, 32'h22); exp_wr(32'h3000_0010, 32'h33);
    exp_wr(32'h3000_0000, 32'h1); exp_wr(32'h3000_0004, 32'hFFFF_FFFF); exp_rd(3);
    exp_job(32'h0, 32'hFFFF_FFFF, 1'b0);
    polls_left = 2; final_status = 32'h0;
    launch(32'd1, 8'd3);
    wait_done(400);
    polls_left = 1; final_status = 32'hC0DE;
    exp_wr(32'h3000_0000, 32'h2); exp_wr(32'h3000_0004, 32'hFFFF_FFFF); exp_rd(2);
    exp_job(32'hC0DE, 32'hFFFF_FFFF, 1'b0);
    launch(32'd2, 8'd0);
    wait_done(400);
    polls_left = 0; final_status = 32'h5;
    exp_wr(32'h3000_0008, 32'hA1); exp_wr(32'h3000_000C, 32'hA2);
    exp_wr(32'h3000_0000, 32'h1); exp_wr(32'h3000_0004, 32'hFFFF_FFFF); exp_rd(1);
    exp_job(32'h5, 32'hFFFF_FFFF, 1'b0);
    dq.push_back(32'hA1);
    launch(32'd1, 8'd2);
    i = 0;
    while (dq.size() != 0 && i < 100) begin
      @(negedge wb_clk_i);
      i++;
    end
    check("first_word_taken", 32'(dq.size()), 32'd0);
    cnt = 0;
    repeat (20) begin
      @(negedge wb_clk_i);
      if (wbm.wbm_cyc_o) cnt++;
    end
    check("no_xfer_without_valid", 32'(cnt), 32'd0);
    check("busy_while_withheld", 32'(busy), 32'd1);
    dq.push_back(32'hA2);
    wait_done(400);
    nak_go = 1'b1;
    exp_wr(32'h3000_0000, 32'h1);
    exp_job(32'hDEAD_0000, 32'hFFFF_0000, 1'b1);
    launch(32'd1, 8'd0);
    wait_done(2000);
    check("timeout_cyc_cycles", 32'(last_run), 32'd1023);
    nak_go = 1'b0;
    polls_left = 0; final_status = 32'h1234;
    dq.push_back(32'h55);
    exp_wr(32'h3000_0008, 32'h55); exp_wr(32'h3000_0000, 32'h2);
    exp_wr(32'h3000_0004, 32'hFFFF_FFFF); exp_rd(1);
    exp_job(32'h1234, 32'hFFFF_FFFF, 1'b0);
    launch(32'd2, 8'd1);
    repeat (2) @(negedge wb_clk_i);
    launch(32'd7, 8'd5);
    wait_done(400);
    repeat (10) @(negedge wb_clk_i);
    check("idle_after_ignored_start", 32'(busy), 32'd0);
    polls_left = 1000;
    exp_wr(32'h3000_0000, 32'h1); exp_wr(32'h3000_0004, 32'hFFFF_FFFF);
    launch(32'd1, 8'd0);
    i = 0;
    while (!(wbm.wbm_cyc_o && !wbm.wbm_we_o) && i < 200) begin
      @(posedge wb_clk_i);
      #1;
      i++;
    end
    check("poll_reached", 32'(wbm.wbm_cyc_o && !wbm.wbm_we_o), 32'd1);
    wb_rst_i = 1'b1;
    #1;
    check("midrst_cyc", 32'(wbm.wbm_cyc_o), 32'd0);
    check("midrst_stb", 32'(wbm.wbm_stb_o), 32'd0);
    check("midrst_sel", 32'(wbm.wbm_sel_o), 32'd0);
    check("midrst_adr", wbm.wbm_adr_o, 32'd0);
    check("midrst_dat", wbm.wbm_dat_o, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done_err", 32'({done, err, din_ready}), 32'd0);
    check("midrst_status", result_status, 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    polls_left = 1; final_status = 32'h77;
    dq.push_back(32'h0A); dq.push_back(32'h0B);
    exp_wr(32'h3000_0008, 32'h0A); exp_wr(32'h3000_000C, 32'h0B);
    exp_wr(32'h3000_0000, 32'h3); exp_wr(32'h3000_0004, 32'hFFFF_FFFF); exp_rd(2);
    exp_job(32'h77, 32'hFFFF_FFFF, 1'b0);
    launch(32'd3, 8'd2);
    wait_done(400);
    repeat (5) @(negedge wb_clk_i);
    check("xq_drained", 32'(xq.size()), 32'd0);
    check("jq_drained", 32'(jq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/accel_job_launcher.md
ACCEL_JOB_LAUNCHER -- requirements
Module: accel_job_launcher

Interface
REQ-001 SHALL have parameter ADDR_OFFSET, default 32'h3000_0000, base address of the accelerator register window.
REQ-002 SHALL have parameter POLL_GAP, default 4, idle cycles between status polls (minimum 1).
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum cycles waiting for wbm_ack_i per transaction.
REQ-004 SHALL have port wb_clk_i  in  1  clock.
REQ-005 SHALL have port wb_rst_i  in  1  reset: asynchronous, active-high.
REQ-006 SHALL have port start  in  1  one-cycle job request.
REQ-007 SHALL have port op  in  32  operation code (1 = multiply, 2 = convolution), sampled on accepted start.
REQ-008 SHALL have port n_words  in  8  data words to load before launch, sampled on accepted start.
REQ-009 SHALL have port din_valid  in  1  load word available.
REQ-010 SHALL have port din  in  32  load word.
REQ-011 SHALL have port din_ready  out  1  load word consumed this cycle.
REQ-012 SHALL have port busy  out  1  job in progress.
REQ-013 SHALL have port done  out  1  one-cycle job-complete pulse.
REQ-014 SHALL have port err  out  1  one-cycle timeout pulse, coincident with done.
REQ-015 SHALL have port result_status  out  32  final status value read back.
REQ-016 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each; wbm_sel_o  out  4; wbm_adr_o, wbm_dat_o  out  32; wbm_dat_i  in  32; wbm_ack_i  in  1 (Wishbone classic master).

Function
REQ-017 SHALL accept start only in IDLE; start while busy is ignored.
REQ-018 SHALL sequence IDLE -> LOAD -> WR_OP -> WR_GO -> POLL_GAP -> POLL_RD -> DONE -> IDLE; LOAD skipped when n_words = 0.
REQ-019 LOAD: word i (0..n_words-1) SHALL be written to ADDR_OFFSET + 8 + 4*i; din_ready pulses one cycle when wbm_ack_i for that write arrives; transaction starts only when din_valid = 1.
REQ-020 WR_OP SHALL write latched op to ADDR_OFFSET + 0.
REQ-021 WR_GO SHALL write 32'hFFFF_FFFF to ADDR_OFFSET + 4.
REQ-022 POLL_GAP SHALL hold cyc/stb low for POLL_GAP cycles, then POLL_RD reads ADDR_OFFSET + 4.
REQ-023 POLL_RD: data 32'hFFFF_FFFF -> POLL_GAP; any other value -> latch into result_status, go DONE.
REQ-024 Each transaction SHALL assert cyc, stb, sel = 4'hF together, hold adr/dat/we stable until wbm_ack_i, deassert cyc and stb the cycle after ack, and keep them low at least one cycle before the next transaction.
REQ-025 Read data SHALL be captured on the cycle wbm_ack_i is high.
REQ-026 A per-transaction counter SHALL abort after TIMEOUT cycles without ack: drop cyc/stb, result_status = 32'hDEAD_0000 | state code, pulse done and err, return IDLE.
REQ-027 done SHALL pulse exactly one cycle in DONE; busy high from cycle after accepted start through DONE cycle inclusive.
REQ-028 Address arithmetic SHALL be 32-bit modulo; word index counter 8 bits, no wrap beyond n_words-1.
REQ-029 wbm_dat_o SHALL be 0 during reads.

Reset
REQ-030 On wb_rst_i all state SHALL clear immediately: state IDLE, wbm_cyc_o/stb_o/we_o = 0, sel = 0, adr = 0, dat = 0, din_ready/busy/done/err = 0, result_status = 0, counters 0.
REQ-031 Reset mid-transaction SHALL drop cyc/stb asynchronously; no partial job resumes after release.

Structure
REQ-032 Shared package SHALL hold state encoding, register offsets (OP 0, STATUS 4, DATA 8), STATUS_GO 32'hFFFF_FFFF, timeout tag 32'hDEAD_0000.
REQ-033 A sub-module wb_master_xfer SHALL implement a single transaction (req/we/adr/dat in; ack/rdata/timeout out) including the TIMEOUT counter; accel_job_launcher holds the sequencing FSM.

Verification
REQ-034 op=1, n_words=3, din 0x11,0x22,0x33, slave acks in 1 cycle -> writes to 0x3000_0008/000C/0010, then 0x3000_0000 <= 1, 0x3000_0004 <= FFFF_FFFF; status returns 0 on 3rd poll -> result_status=0, done one pulse, err=0.
REQ-035 n_words=0, op=2 -> no data writes; first transaction is 0x3000_0000 <= 2.
REQ-036 din_valid withheld 20 cycles during LOAD -> cyc stays low, no write issued, resumes on valid.
REQ-037 slave never acks WR_GO -> after 1023 cycles cyc drops, done and err pulse same cycle, result_status upper half 0xDEAD.
REQ-038 start asserted while busy -> ignored; op latched from first start persists.
REQ-039 wb_rst_i asserted mid-POLL_RD -> cyc/stb low same cycle, all outputs zero, next start runs full sequence.
